// File: rtl/output_delta_gen_if.sv
// Stream bundle for the output-layer delta generator: act/adot beats in,
// delta beats out, plus the per-sample prediction report.
interface output_delta_gen_if #(
  parameter int n     = 16,
  parameter int zn    = 2,
  parameter int width = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [width*zn-1:0]    act_in_package;
  logic [width*zn-1:0]    adot_in_package;
  logic [$clog2(n)-1:0]   label;
  logic                   out_valid;
  logic                   out_ready;
  logic [width*zn-1:0]    del_out_package;
  logic                   out_last;
  logic                   pred_valid;
  logic                   pred_correct;

  modport master (
    output in_valid, act_in_package, adot_in_package, label, out_ready,
    input  in_ready, out_valid, del_out_package, out_last, pred_valid, pred_correct
  );

  modport slave (
    input  in_valid, act_in_package, adot_in_package, label, out_ready,
    output in_ready, out_valid, del_out_package, out_last, pred_valid, pred_correct
  );
endinterface

// File: rtl/output_delta_gen.sv
// Output-layer error source: del = (a - onehot(label)) * a' per neuron,
// buffered in a small FIFO, with argmax-vs-label prediction reporting.
module output_delta_gen #(
  parameter int n        = 16,
  parameter int zn       = 2,
  parameter int width    = 16,
  parameter int int_bits = 5,
  parameter int depth    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  output_delta_gen_if.slave  bus
);

  localparam int FRAC = width - int_bits - 1;
  localparam int NB   = n / zn;
  localparam int CW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW   = (n > 1) ? $clog2(n) : 1;
  localparam int AW   = $clog2(depth);
  localparam int PW   = 2 * width + 2;
  localparam int DW   = width * zn;

  logic [CW-1:0]    r_beat;
  logic [LW-1:0]    r_label;
  logic [LW-1:0]    r_max_idx;
  logic [width-1:0] r_max_val;
  logic             r_pred_valid;
  logic             r_pred_correct;
  logic [DW:0]      r_mem [depth];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;

  logic             w_first;
  logic             w_last_beat;
  logic [LW-1:0]    w_label_eff;
  logic [LW-1:0]    w_base;
  logic [DW-1:0]    w_del_pkg;
  logic [width-1:0] w_mv;
  logic [LW-1:0]    w_mi;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DW:0]      w_head;
  logic [width:0]   w_one;

  assign w_first     = (r_beat == '0);
  assign w_last_beat = (r_beat == CW'(NB - 1));
  assign w_label_eff = w_first ? bus.label : r_label;
  assign w_base      = LW'(r_beat) * LW'(zn);
  assign w_one       = {{(width - FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

  for (genvar g = 0; g < zn; g++) begin : g_slice
    logic [width-1:0]        w_act;
    logic [width-1:0]        w_adot;
    logic                    w_hit;
    logic signed [width:0]   w_y;
    logic signed [width:0]   w_diff;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_res;
    logic [PW-width:0]       w_top;
    logic [width-1:0]        w_sat;

    assign w_act  = bus.act_in_package[g*width +: width];
    assign w_adot = bus.adot_in_package[g*width +: width];
    assign w_hit  = ((w_base + LW'(g)) == w_label_eff);
    assign w_y    = w_hit ? w_one : '0;
    assign w_diff = $signed({1'b0, w_act}) - w_y;
    // Operands pre-extended to full product width so the low PW bits are exact.
    assign w_prod = {{(width + 1){w_diff[width]}}, w_diff} * {{(width + 2){1'b0}}, w_adot};
    assign w_res  = w_prod >>> FRAC;
    assign w_top  = w_res[PW-1:width-1];
    assign w_sat  = (&w_top || ~|w_top) ? w_res[width-1:0]
                  : (w_res[PW-1] ? {1'b1, {(width - 1){1'b0}}} : {1'b0, {(width - 1){1'b1}}});
    assign w_del_pkg[g*width +: width] = w_sat;
  end

  // Strictly-greater update, low slice first: ties keep the lowest index.
  always_comb begin
    w_mv = w_first ? '0 : r_max_val;
    w_mi = w_first ? '0 : r_max_idx;
    for (int unsigned i = 0; i < zn; i++) begin
      if (bus.act_in_package[i*width +: width] > w_mv) begin
        w_mv = bus.act_in_package[i*width +: width];
        w_mi = w_base + LW'(i);
      end
    end
  end

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = bus.in_valid && !w_full;
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_head  = r_mem[r_rp[AW-1:0]];

  assign bus.in_ready        = !w_full;
  assign bus.out_valid       = !w_empty;
  assign bus.del_out_package = w_empty ? '0 : w_head[DW-1:0];
  assign bus.out_last        = !w_empty && w_head[DW];
  assign bus.pred_valid      = r_pred_valid;
  assign bus.pred_correct    = r_pred_correct;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {w_last_beat, w_del_pkg};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat         <= '0;
      r_label        <= '0;
      r_max_idx      <= '0;
      r_max_val      <= '0;
      r_pred_valid   <= 1'b0;
      r_pred_correct <= 1'b0;
      r_wp           <= '0;
      r_rp           <= '0;
    end else begin
      r_pred_valid <= w_push && w_last_beat;
      if (w_push) begin
        r_wp      <= r_wp + (AW + 1)'(1);
        r_beat    <= w_last_beat ? '0 : r_beat + CW'(1);
        r_max_val <= w_mv;
        r_max_idx <= w_mi;
        if (w_first) r_label <= bus.label;
        if (w_last_beat) r_pred_correct <= (w_mi == w_label_eff);
      end
      if (w_pop) r_rp <= r_rp + (AW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_output_delta_gen.sv
// Directed bench for output_delta_gen with n=4, zn=2, width=16, depth=4.
module tb_output_delta_gen;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] bp_act [4] = '{32'h0011_0010, 32'h0413_0012, 32'h0021_0020, 32'h0423_0022};
  logic [31:0] bp_del [4] = '{32'h0011_0010, 32'h0013_0012, 32'h0021_0020, 32'h0023_0022};

  always #5 clk = ~clk;

  output_delta_gen_if #(.n(4), .zn(2), .width(16)) bus ();

  output_delta_gen #(.n(4), .zn(2), .width(16), .int_bits(5), .depth(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] d, input logic l);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, "_del"}, bus.del_out_package, d);
    check({tag, "_last"}, 32'(bus.out_last), 32'(l));
  endtask

  task automatic push(input logic [31:0] act, input logic [31:0] adot, input logic [1:0] lab);
    int t;
    @(negedge clk);
    bus.act_in_package  = act;
    bus.adot_in_package = adot;
    bus.label           = lab;
    bus.in_valid        = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n             = 1'b0;
    bus.in_valid        = 1'b0;
    bus.out_ready       = 1'b0;
    bus.act_in_package  = '0;
    bus.adot_in_package = '0;
    bus.label           = '0;
    repeat (3) @(posedge clk);
    #1;
    check_head("rst", 1'b0, 32'h0, 1'b0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("rst_pred_correct", 32'(bus.pred_correct), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic sample, label 1, tie on 0x0300 keeps index 0
    push(32'h0300_0300, 32'h00C0_00C0, 2'd1);
    check_head("t1_b0", 1'b1, 32'hFFD0_0090, 1'b0);
    push(32'h0200_0100, 32'h0100_0100, 2'd1);
    check("t1_pred_valid", 32'(bus.pred_valid), 32'd1);
    check("t1_pred_correct", 32'(bus.pred_correct), 32'd0);
    check_head("t1_hold", 1'b1, 32'hFFD0_0090, 1'b0);
    @(posedge clk);
    #1;
    check("t1_pred_pulse", 32'(bus.pred_valid), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_head("t1_b1", 1'b1, 32'h0080_0040, 1'b1);
    @(posedge clk);
    #1;
    check_head("t1_empty", 1'b0, 32'h0, 1'b0);

    // Saturation, label 0
    push(32'h7FFF_0000, 32'h7FFF_7FFF, 2'd0);
    check_head("t2_b0", 1'b1, 32'h7FFF_8001, 1'b0);
    push(32'h0000_0000, 32'h0000_0000, 2'd0);
    check_head("t2_b1", 1'b1, 32'h0000_0000, 1'b1);
    check("t2_pred_valid", 32'(bus.pred_valid), 32'd1);
    check("t2_pred_correct", 32'(bus.pred_correct), 32'd0);

    // Label latched on beat 0 survives a label change on beat 1
    push(32'h0100_0400, 32'h0400_0400, 2'd2);
    check_head("t3_b0", 1'b1, 32'h0100_0400, 1'b0);
    push(32'h0200_0800, 32'h0100_0100, 2'd0);
    check_head("t3_b1", 1'b1, 32'h0080_0100, 1'b1);
    check("t3_pred_valid", 32'(bus.pred_valid), 32'd1);
    check("t3_pred_correct", 32'(bus.pred_correct), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t3_pred_valid_off", 32'(bus.pred_valid), 32'd0);
    check("t3_pred_correct_hold", 32'(bus.pred_correct), 32'd1);

    // Negative saturation, all-zero argmax
    push(32'h0000_0000, 32'hFFFF_0000, 2'd1);
    check_head("t4_b0", 1'b1, 32'h8000_0000, 1'b0);
    push(32'h0000_0000, 32'h0000_0000, 2'd1);
    check_head("t4_b1", 1'b1, 32'h0000_0000, 1'b1);
    check("t4_pred_correct", 32'(bus.pred_correct), 32'd0);
    @(posedge clk);
    #1;
    check("t4_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: fill, then drain with in_valid held
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.act_in_package  = bp_act[i];
      bus.adot_in_package = 32'h0400_0400;
      bus.label           = 2'd3;
      bus.in_valid        = 1'b1;
      check("bp_ready_pre", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
    end
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    check_head("bp_h0", 1'b1, bp_del[0], 1'b0);
    bus.act_in_package = 32'h0031_0030;
    bus.out_ready      = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
    check_head("bp_h1", 1'b1, bp_del[1], 1'b1);
    @(posedge clk);
    #1;
    check_head("bp_h2", 1'b1, bp_del[2], 1'b0);
    check("bp_ready_steady", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_head("bp_h3", 1'b1, bp_del[3], 1'b1);
    @(posedge clk);
    #1;
    check_head("bp_h4", 1'b1, 32'h0031_0030, 1'b0);
    @(posedge clk);
    #1;
    check_head("bp_empty", 1'b0, 32'h0, 1'b0);

    // Reset mid-sample with two entries queued
    bus.out_ready = 1'b0;
    push(32'h0000_0000, 32'h0000_0000, 2'd0);
    push(32'h0001_0001, 32'h0000_0000, 2'd2);
    check_head("t6_queued", 1'b1, 32'h0000_0000, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_head("t6_async", 1'b0, 32'h0, 1'b0);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    push(32'h0500_0000, 32'h0400_0400, 2'd1);
    check_head("t6_b0", 1'b1, 32'h0100_0000, 1'b0);
    push(32'h0400_0000, 32'h0400_0400, 2'd3);
    check_head("t6_b1", 1'b1, 32'h0400_0000, 1'b1);
    check("t6_pred_valid", 32'(bus.pred_valid), 32'd1);
    check("t6_pred_correct", 32'(bus.pred_correct), 32'd1);
    @(posedge clk);
    #1;
    check("t6_pred_pulse", 32'(bus.pred_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_delta_gen.md
Name: output_delta_gen

Overview:
- Output-layer error source for training: consumes the last layer's act_out/adot_out beats from the FF processor sets and produces del_in beats for the BP processor sets.
- Per neuron: del = (a - y) * a', where y is the one-hot ideal output taken from the sample label.
- Buffers deltas in a small FIFO with a valid/ready handshake on both sides.
- Also reports whether the network's prediction (argmax of activations) matched the label.

Parameters:
- n, 16, neurons in output layer; must be a multiple of zn.
- zn, 2, neurons per beat (z/fi of the last junction).
- width, 16, data word width in bits.
- int_bits, 5, integer bits; frac_bits = width-int_bits-1 = 10.
- depth, 4, delta FIFO depth in beats; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  act/adot beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- act_in_package  in  width*zn  zn unsigned activations; neuron k*zn+i occupies slice i.
- adot_in_package  in  width*zn  zn unsigned activation derivatives, same packing.
- label  in  $clog2(n)  correct class; sampled on the first beat of each sample.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  BP side accepts head.
- del_out_package  out  width*zn  signed deltas, same packing as input.
- out_last  out  1  head beat is the final beat of a sample.
- pred_valid  out  1  one-cycle pulse per completed sample.
- pred_correct  out  1  argmax equals label; valid while pred_valid.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; beat counter 0; latched label 0; argmax value/index 0.
  - out_valid=0, out_last=0, del_out_package=0, pred_valid=0, pred_correct=0, in_ready=1.
- Beat counter runs 0..n/zn-1 and advances only on an input handshake; it wraps to 0 after the last beat.
- Label handling:
  - On a handshake with counter==0, label is latched.
  - Beats 0 and later use the effective label: the live label on beat 0, the latched label afterwards.
  - Label changes at any other time are ignored.
- Per slice i on beat k: idx = k*zn+i; y = (idx==label_eff) ? 1<<frac_bits : 0.
- Arithmetic:
  - diff = {1'b0,a} - y, computed at width+1 bits, signed.
  - prod = diff * adot, signed with adot zero-extended.
  - res = prod >>> frac_bits (arithmetic shift, truncation toward minus infinity).
  - Saturate res to width bits: above 0x7FFF gives 0x7FFF; below 0x8000 (signed) gives 0x8000.
- Computation is combinational from the handshake. The result is written into the FIFO in the same cycle, with out_last = (k==n/zn-1).
- FIFO:
  - in_ready = !full. It does not depend on out_ready.
  - Pop on out_valid && out_ready.
  - out_valid = !empty; del_out_package and out_last show the head entry, and are zero when empty.
  - Push and pop in the same cycle: occupancy is unchanged.
  - When full, in_ready=0 in that cycle even if a pop occurs.
  - Pointers wrap modulo depth.
  - Input-to-output latency: 1 cycle (pushed data is visible at the head the next cycle when the FIFO was empty).
- Argmax:
  - Over all accepted beats of a sample, compare activations as unsigned values.
  - A strictly greater value replaces the current max, so ties keep the lowest index.
  - Beat 0 starts fresh: the running max is ignored.
  - Slices within a beat are evaluated low index first.
- Prediction report:
  - On the handshake of the last beat, the cycle after has pred_valid=1 for exactly one cycle.
  - pred_correct = (final argmax index == label_eff). The final argmax includes the current beat.
  - pred_correct holds its value until the next pred_valid.
- Input stall: with in_valid low, nothing advances; the counter, latched label and argmax hold.
- Reset mid-sample: the partial sample is discarded, the FIFO is flushed, and the next accepted beat is treated as beat 0.

Test Plan:
- n=4, zn=2, label=1; beat0 act={0x0300,0x0300} (slice0,slice1), adot={0x00C0,0x00C0} -> head del={0x0090,0xFFD0}, out_last=0, out_valid one cycle after handshake.
- Beat1 act={0x0100,0x0200}, adot=0x0100 -> del={0x0040,0x0080}, out_last=1; pred_valid pulses one cycle later with pred_correct=0 (argmax index 0, since 0x0300 ties keep index 0).
- Saturation: label=0; non-label slice with act=0x7FFF, adot=0x7FFF -> del=0x7FFF. Label slice with act=0, adot=0x7FFF -> diff=-1024, del=0x8001 (-32767, no saturation).
- Backpressure: out_ready=0, push 4 beats -> in_ready=0 after the 4th. Then out_ready=1 with in_valid held high -> one pop per cycle; in_ready rises one cycle after the first pop; FIFO order is preserved with no loss or duplication.
- Label latching: label=2 on beat0, then change label to 0 during beat1 -> beat1 deltas still use y=1.0 at idx 2, and pred_correct is computed against 2.
- Deassert reset_n while 2 entries are queued, mid-sample -> out_valid=0 immediately (async). After release, the next beat is beat0 and the new label is latched.
